l15_mem_responder: RTL and testbench

- Behavioural L1.5 responder for the far end of the core tile's L1.5 request/return interface.
- Accepts L1.5 requests (IMISS, LOAD, STORE), services them from a small internal word memory after a programmable latency, and drives L1.5 return packets.
- Used as the L1.5/L2 stand-in for tile-level simulation and FPGA bring-up without the OpenPiton uncore.

---
 rtl/l15_mem_responder_if.sv | 40 ++++
 rtl/l15_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_l15_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l15_mem_responder_if.sv
// L1.5 request/return channel between a core tile (master) and the
// responder standing in for the L1.5/L2 (slave).
interface l15_mem_responder_if #(
    parameter int AddrWidth = 40
);
    logic                 req_val;
    logic [4:0]           req_rqtype;
    logic                 req_nc;
    logic [2:0]           req_size;
    logic                 req_threadid;
    logic [AddrWidth-1:0] req_address;
    logic [63:0]          req_data;
    logic                 req_ack;

    logic                 rtrn_val;
    logic                 rtrn_ack;
    logic [3:0]           rtrn_returntype;
    logic                 rtrn_nc;
    logic                 rtrn_threadid;
    logic [63:0]          rtrn_data_0;
    logic [63:0]          rtrn_data_1;
    logic [63:0]          rtrn_data_2;
    logic [63:0]          rtrn_data_3;

    modport master (
        output req_val, req_rqtype, req_nc, req_size, req_threadid, req_address, req_data,
        output rtrn_ack,
        input  req_ack,
        input  rtrn_val, rtrn_returntype, rtrn_nc, rtrn_threadid,
        input  rtrn_data_0, rtrn_data_1, rtrn_data_2, rtrn_data_3
    );

    modport slave (
        input  req_val, req_rqtype, req_nc, req_size, req_threadid, req_address, req_data,
        input  rtrn_ack,
        output req_ack,
        output rtrn_val, rtrn_returntype, rtrn_nc, rtrn_threadid,
        output rtrn_data_0, rtrn_data_1, rtrn_data_2, rtrn_data_3
    );
endinterface

// File: rtl/l15_mem_responder.sv
// Behavioural L1.5 responder: serves IMISS/LOAD/STORE requests from a small
// word memory after a fixed latency and holds each return until consumed.
module l15_mem_responder #(
    parameter int MemWords  = 1024,
    parameter int Latency   = 4,
    parameter int AddrWidth = 40
) (
    input  logic                clk_i,
    input  logic                rst_i,
    l15_mem_responder_if.slave  l15,
    output logic                err_o,
    output logic [31:0]         resp_cnt_o
);
    localparam int         IdxW    = $clog2(MemWords);
    localparam logic [7:0] LatInit = 8'(Latency - 1);

    localparam logic [4:0] LoadRq  = 5'h00;
    localparam logic [4:0] StoreRq = 5'h01;
    localparam logic [4:0] ImissRq = 5'h10;

    localparam logic [3:0] LoadRet  = 4'h0;
    localparam logic [3:0] IfillRet = 4'h1;
    localparam logic [3:0] StAck    = 4'h4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state;
    logic [7:0]      cnt;

    logic [4:0]      cap_type;
    logic            cap_nc;
    logic            cap_tid;
    logic            cap_bad;
    logic            cap_misal;
    logic [7:0]      cap_be;
    logic [IdxW-1:0] cap_idx;
    logic [63:0]     cap_data;

    logic            req_ack;
    logic            req_bad;
    logic            req_misal;
    logic [7:0]      size_mask;
    logic [2:0]      req_off;

    logic [63:0]     mem [MemWords];
    logic            mem_we;
    logic [IdxW-1:0] base2;
    logic [IdxW-1:0] base4;

    logic            rtrn_val;
    logic [3:0]      rtrn_type;
    logic            rtrn_nc;
    logic            rtrn_tid;
    logic [3:0][63:0] rtrn_d;

    assign req_ack     = (state == ST_IDLE) && l15.req_val && !rst_i;
    assign l15.req_ack = req_ack;
    assign req_off     = l15.req_address[2:0];
    assign req_bad     = (l15.req_rqtype != LoadRq) && (l15.req_rqtype != StoreRq) &&
                         (l15.req_rqtype != ImissRq);

    // Byte-lane mask for the access size; sizes above 8B count as misaligned.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        size_mask = 8'h00;
        req_misal = 1'b1;
        case (l15.req_size)
            3'd0: begin size_mask = 8'h01; req_misal = 1'b0;          end
            3'd1: begin size_mask = 8'h03; req_misal = req_off[0];    end
            3'd2: begin size_mask = 8'h0f; req_misal = |req_off[1:0]; end
            3'd3: begin size_mask = 8'hff; req_misal = |req_off;      end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (req_ack) begin
            cap_type  <= l15.req_rqtype;
            cap_nc    <= l15.req_nc;
            cap_tid   <= l15.req_threadid;
            cap_bad   <= req_bad;
            cap_misal <= req_misal;
            cap_be    <= 8'(size_mask << req_off);
            cap_idx   <= l15.req_address[3 +: IdxW];
            cap_data  <= l15.req_data;
        end
    end

    assign base2  = {cap_idx[IdxW-1:1], 1'b0};
    assign base4  = {cap_idx[IdxW-1:2], 2'b00};
    assign mem_we = (state == ST_WAIT) && (cnt == 8'd0) && (cap_type == StoreRq) &&
                    !cap_misal && !rst_i;

    // NOTE: the memory is deliberately not reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (cap_be[b]) mem[cap_idx][8*b +: 8] <= cap_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            err_o      <= 1'b0;
            resp_cnt_o <= '0;
            rtrn_val   <= 1'b0;
            rtrn_type  <= '0;
            rtrn_nc    <= 1'b0;
            rtrn_tid   <= 1'b0;
            rtrn_d     <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_ack) begin
                        cnt   <= LatInit;
                        err_o <= req_bad || ((l15.req_rqtype == StoreRq) && req_misal);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cap_bad) begin
                        state <= ST_IDLE;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        rtrn_val <= 1'b1;
                        rtrn_nc  <= cap_nc;
                        rtrn_tid <= cap_tid;
                        state    <= ST_RESP;
                        case (cap_type)
                            ImissRq: begin
                                rtrn_type <= IfillRet;
                                rtrn_d[0] <= mem[base4];
                                rtrn_d[1] <= mem[base4 | IdxW'(1)];
                                rtrn_d[2] <= mem[base4 | IdxW'(2)];
                                rtrn_d[3] <= mem[base4 | IdxW'(3)];
                            end
                            LoadRq: begin
                                rtrn_type <= LoadRet;
                                rtrn_d[0] <= cap_nc ? mem[cap_idx] : mem[base2];
                                rtrn_d[1] <= cap_nc ? mem[cap_idx] : mem[base2 | IdxW'(1)];
                                rtrn_d[2] <= '0;
                                rtrn_d[3] <= '0;
                            end
                            default: begin
                                rtrn_type <= StAck;
                                rtrn_d    <= '0;
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    if (l15.rtrn_ack) begin
                        rtrn_val   <= 1'b0;
                        state      <= ST_IDLE;
                        resp_cnt_o <= resp_cnt_o + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign l15.rtrn_val        = rtrn_val;
    assign l15.rtrn_returntype = rtrn_type;
    assign l15.rtrn_nc         = rtrn_nc;
    assign l15.rtrn_threadid   = rtrn_tid;
    assign l15.rtrn_data_0     = rtrn_d[0];
    assign l15.rtrn_data_1     = rtrn_d[1];
    assign l15.rtrn_data_2     = rtrn_d[2];
    assign l15.rtrn_data_3     = rtrn_d[3];
endmodule

// File: tb/tb_l15_mem_responder.sv
// Scoreboard bench for l15_mem_responder: a byte-level memory model predicts
// each return, and a monitor consumes returns with random back-pressure.
module tb_l15_mem_responder;
    localparam int         Lat   = 4;
    localparam logic [4:0] LOAD  = 5'h00;
    localparam logic [4:0] STORE = 5'h01;
    localparam logic [4:0] IMISS = 5'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err;
    logic [31:0] resp_cnt;

    l15_mem_responder_if #(.AddrWidth(40)) bus ();

    l15_mem_responder #(.MemWords(1024), .Latency(Lat), .AddrWidth(40)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .l15        (bus),
        .err_o      (err),
        .resp_cnt_o (resp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       rtype;
        logic             nc;
        logic             tid;
        logic [3:0][63:0] d;
        int               ack_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mdl [1024];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          fixed_hold = -1;
    logic [31:0] exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Issue one request, update the reference memory, queue the expected return.
    task automatic do_req(input logic [4:0] t, input logic nc, input logic [2:0] sz,
                          input logic tid, input logic [39:0] a, input logic [63:0] d,
                          output int acyc);
        exp_t e;
        logic exp_err;
        int   w, base, off, nb;
        bit   got;
        @(negedge clk);
        bus.req_rqtype   = t;
        bus.req_nc       = nc;
        bus.req_size     = sz;
        bus.req_threadid = tid;
        bus.req_address  = a;
        bus.req_data     = d;
        bus.req_val      = 1'b1;
        got  = 0;
        acyc = -1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.req_ack) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check("req_ack_timeout", 1'b0, 1'b1);
            bus.req_val = 1'b0;
            return;
        end
        acyc = cyc;
        check("ack_while_rtrn_val", bus.rtrn_val, 1'b0);

        w   = (int'(a) >> 3) % 1024;
        off = int'(a) % 8;
        nb  = 1 << sz;
        e.rtype   = 4'h0;
        e.nc      = nc;
        e.tid     = tid;
        e.d       = '0;
        e.ack_cyc = cyc + 1;
        exp_err   = 1'b0;
        case (t)
            IMISS: begin
                e.rtype = 4'h1;
                base = w - (w % 4);
                for (int k = 0; k < 4; k++) e.d[k] = mdl[base + k];
            end
            LOAD: begin
                e.rtype = 4'h0;
                if (nc) begin
                    e.d[0] = mdl[w];
                    e.d[1] = mdl[w];
                end else begin
                    base = w - (w % 2);
                    e.d[0] = mdl[base];
                    e.d[1] = mdl[base + 1];
                end
            end
            STORE: begin
                e.rtype = 4'h4;
                if (off % nb != 0) exp_err = 1'b1;
                else for (int k = 0; k < nb; k++) mdl[w][8*(off+k) +: 8] = d[8*(off+k) +: 8];
            end
            default: exp_err = 1'b1;
        endcase
        if (t == LOAD || t == STORE || t == IMISS) exp_q.push_back(e);

        @(negedge clk);
        bus.req_val = 1'b0;
        check("err_o", err, exp_err);
        @(negedge clk);
        check("err_pulse_end", err, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.rtrn_val); i++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on each new return, checks it every valid
    // cycle (stability), drives rtrn_ack and tracks completions.
    initial begin
        exp_t cur;
        bit   have, prev_val, prev_ack;
        int   held, target;
        have = 0; prev_val = 0; prev_ack = 0; held = 0; target = 0;
        bus.rtrn_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_cnt = 0;
                prev_val = 0;
                prev_ack = 0;
                bus.rtrn_ack = 1'b0;
                continue;
            end
            if (prev_val && prev_ack) begin
                exp_cnt++;
                done_cyc = cyc;
                check("resp_cnt", resp_cnt, exp_cnt);
            end
            if (bus.rtrn_val) begin
                if (!prev_val || prev_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_return", 1'b1, 1'b0);
                        have = 0;
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1;
                        check("latency", 64'(cyc - cur.ack_cyc), 64'(Lat));
                    end
                    target = (fixed_hold >= 0) ? fixed_hold : $urandom_range(0, 2);
                    held   = 0;
                end
                if (have) begin
                    check("returntype", bus.rtrn_returntype, cur.rtype);
                    check("rtrn_nc", bus.rtrn_nc, cur.nc);
                    check("rtrn_threadid", bus.rtrn_threadid, cur.tid);
                    check("data_0", bus.rtrn_data_0, cur.d[0]);
                    check("data_1", bus.rtrn_data_1, cur.d[1]);
                    check("data_2", bus.rtrn_data_2, cur.d[2]);
                    check("data_3", bus.rtrn_data_3, cur.d[3]);
                end
                if (held >= target) bus.rtrn_ack = 1'b1;
                else begin
                    bus.rtrn_ack = 1'b0;
                    held++;
                end
            end else begin
                bus.rtrn_ack = 1'($urandom_range(0, 1));
            end
            prev_val = bus.rtrn_val;
            prev_ack = bus.rtrn_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int          acyc, tmp, w;
        logic [4:0]  t;
        logic [4:0]  bad_types [3];
        bad_types = '{5'h07, 5'h02, 5'h1f};

        // Reset with a request already pending.
        bus.req_val      = 1'b1;
        bus.req_rqtype   = LOAD;
        bus.req_nc       = 1'b1;
        bus.req_size     = 3'd3;
        bus.req_threadid = 1'b0;
        bus.req_address  = 40'h100;
        bus.req_data     = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ack", bus.req_ack, 1'b0);
        check("rst_rtrn_val", bus.rtrn_val, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_resp_cnt", resp_cnt, 32'd0);
        check("rst_returntype", bus.rtrn_returntype, 4'h0);
        check("rst_data_0", bus.rtrn_data_0, 64'd0);
        check("rst_data_3", bus.rtrn_data_3, 64'd0);
        rst = 1'b0;
        #1;
        check("req_ack_after_reset", bus.req_ack, 1'b1);
        bus.req_val = 1'b0;

        // Initialise the words used below, with aliasing upper address bits.
        for (int i = 0; i < 128; i++)
            do_req(STORE, 1'($urandom), 3'd3, 1'($urandom), {27'($urandom), 10'(i), 3'b000},
                   {$urandom, $urandom}, acyc);

        do_req(STORE, 1'b0, 3'd3, 1'b0, 40'h100, 64'h1122334455667788, acyc);
        do_req(LOAD,  1'b1, 3'd3, 1'b1, 40'h100, 64'd0, acyc);
        do_req(STORE, 1'b0, 3'd0, 1'b0, 40'h103, 64'h00000000AA000000, acyc);
        do_req(LOAD,  1'b1, 3'd3, 1'b0, 40'h100, 64'd0, acyc);
        for (int k = 0; k < 4; k++)
            do_req(STORE, 1'b0, 3'd3, 1'b0, 40'h200 + 40'(8 * k), 64'(k + 1), acyc);
        do_req(IMISS, 1'b0, 3'd3, 1'b1, 40'h20C, 64'd0, acyc);
        do_req(LOAD,  1'b0, 3'd3, 1'b0, 40'h218, 64'd0, acyc);

        // Back-pressure: return held 10 cycles, second request must wait.
        fixed_hold = 10;
        do_req(LOAD, 1'b1, 3'd3, 1'b0, 40'h200, 64'd0, acyc);
        do_req(LOAD, 1'b0, 3'd3, 1'b1, 40'h208, 64'd0, acyc);
        check("ack_cycle_after_release", 64'(acyc), 64'(done_cyc));
        fixed_hold = -1;

        // Misaligned store and unsupported request type.
        do_req(STORE, 1'b0, 3'd2, 1'b0, 40'h102, 64'hdeadbeefcafef00d, acyc);
        do_req(LOAD,  1'b1, 3'd3, 1'b0, 40'h100, 64'd0, acyc);
        do_req(5'h07, 1'b0, 3'd3, 1'b0, 40'h100, 64'd0, acyc);
        repeat (Lat + 4) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            tmp = $urandom_range(0, 9);
            if (tmp < 3)      t = LOAD;
            else if (tmp < 6) t = STORE;
            else if (tmp < 9) t = IMISS;
            else              t = bad_types[$urandom_range(0, 2)];
            w = $urandom_range(0, 127);
            do_req(t, 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                   {27'($urandom), 10'(w), 3'($urandom)}, {$urandom, $urandom}, acyc);
        end
        drain();

        // Reset while waiting: the store is dropped and no return appears.
        @(negedge clk);
        bus.req_rqtype  = STORE;
        bus.req_size    = 3'd3;
        bus.req_address = 40'h100;
        bus.req_data    = 64'hffff_ffff_ffff_ffff;
        bus.req_val     = 1'b1;
        #1;
        check("ack_before_mid_reset", bus.req_ack, 1'b1);
        @(negedge clk);
        bus.req_val = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < Lat + 4; i++) begin
            @(negedge clk);
            check("no_return_after_reset", bus.rtrn_val, 1'b0);
        end
        check("resp_cnt_cleared", resp_cnt, 32'd0);
        do_req(LOAD, 1'b1, 3'd3, 1'b0, 40'h100, 64'd0, acyc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
